// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared types, widths and address helper for the RF writeback arbiter
//
// Package rf_wb_pkg:
//   state_t    : arbiter FSM state (IDLE / BURST)
//   REG_W      : register-file address width
//   DATA_W     : register-file data width
//   REQ_*      : requester slot indices (ALU, load unit, crypto core)
//   next_reg() : burst address increment; 31 wraps to 1 and register 0 is never produced
package rf_wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_CRYPTO = 2;

    // Register 0 is hard-wired, so a burst must never land on it: both 0 and
    // 31 step to 1.
    function automatic logic [REG_W-1:0] next_reg(input logic [REG_W-1:0] addr);
        if (addr == '1 || addr == '0) begin
            return REG_W'(1);
        end
        return addr + 1'b1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - requester and RF write-port bundle for the writeback arbiter
//
// Parameter NUM_REQ : number of requesters.
// Signals:
//   req_valid/req_ready/req_last [NUM_REQ]   per-requester beat handshake
//   req_base [NUM_REQ*REG_W]                 burst start register per requester
//   req_data [NUM_REQ*DATA_W]                beat data per requester
//   rf_we/rf_waddr/rf_wdata                  registered RF write port
//   busy, len_err                            lock status, truncation pulse
//   timeout_err                              idle-lock abort pulse (only with RF_WB_TIMEOUT_EN)
// Modports: master = requester/RF side, slave = arbiter.
interface rf_wb_arbiter_if
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*REG_W-1:0]  req_base;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      rf_we;
    logic [REG_W-1:0]          rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      busy;
    logic                      len_err;
`ifdef RF_WB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    modport master (
`ifdef RF_WB_TIMEOUT_EN
        input  timeout_err,
`endif
        output req_valid, req_last, req_base, req_data,
        input  req_ready, rf_we, rf_waddr, rf_wdata, busy, len_err
    );

    modport slave (
`ifdef RF_WB_TIMEOUT_EN
        output timeout_err,
`endif
        input  req_valid, req_last, req_base, req_data,
        output req_ready, rf_we, rf_waddr, rf_wdata, busy, len_err
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rtl/rf_wb_arbiter_rr_pick.sv - combinational round-robin priority picker
//
// Module rr_pick (parameter N):
//   valid_i [N]        request vector
//   ptr_i   [IDX_W]    highest-priority index this cycle
//   grant_o [N]        one-hot grant of the first valid index at or after ptr_i (zero if none)
//   idx_o   [IDX_W]    index of grant_o (zero if none)
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && valid_i[IDX_W'(j)]) begin
                found               = 1'b1;
                grant_o[IDX_W'(j)]  = 1'b1;
                idx_o               = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin arbiter sharing the RF write port, with locked bursts
//
// Optional feature macro: RF_WB_TIMEOUT_EN (abort a stalled burst after TIMEOUT idle cycles).
// Parameters: NUM_REQ (requesters), MAX_BURST (beats per burst cap), TIMEOUT (idle limit).
// Ports:
//   clk    : clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : rf_wb_arbiter_if.slave - requester handshakes, RF write port, busy,
//            len_err and (with the macro) timeout_err
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [REG_W-1:0]   next_addr_q, next_addr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [REG_W-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_q;
    logic               len_err_q, len_err_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic [IDX_W-1:0]   sel;
    logic [REG_W-1:0]   beat_addr;
    logic [DATA_W-1:0]  beat_data;
    logic               beat_last;
    logic               accept;
    logic               at_cap;

`ifdef RF_WB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        if (int'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // State register and registered RF write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            next_addr_q <= '0;
            beat_cnt_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            len_err_q   <= 1'b0;
`ifdef RF_WB_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            next_addr_q <= next_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            rf_we_q     <= rf_we_d;
            len_err_q   <= len_err_d;
            // Address/data only move on a real write so they hold otherwise.
            if (rf_we_d) begin
                rf_waddr_q <= beat_addr;
                rf_wdata_q <= beat_data;
            end
`ifdef RF_WB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Output/grant decode: same-cycle grant in IDLE, owner-only in BURST.
    always_comb begin
        req_ready = '0;
        sel       = (state_q == BURST) ? owner_q : pick_idx;
        if (rst_n) begin
            if (state_q == BURST) begin
                req_ready[owner_q] = 1'b1;
            end else begin
                req_ready = pick_grant;
            end
        end
    end

    assign beat_addr = (state_q == BURST) ? next_addr_q
                                          : bus.req_base[int'(sel)*REG_W +: REG_W];
    assign beat_data = bus.req_data[int'(sel)*DATA_W +: DATA_W];
    assign beat_last = bus.req_last[sel];
    assign accept    = |(bus.req_valid & req_ready);
    assign at_cap    = (state_q == BURST) && (beat_cnt_q == CNT_W'(MAX_BURST - 1));

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        next_addr_d = next_addr_q;
        beat_cnt_d  = beat_cnt_q;
        // A beat aimed at register 0 is consumed but never written.
        rf_we_d     = accept && (beat_addr != '0);
        len_err_d   = 1'b0;
`ifdef RF_WB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (beat_last) begin
                        rr_ptr_d = ptr_inc(sel);
                    end else begin
                        state_d     = BURST;
                        owner_d     = sel;
                        next_addr_d = next_reg(beat_addr);
                        beat_cnt_d  = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    next_addr_d = next_reg(next_addr_q);
                    beat_cnt_d  = beat_cnt_q + 1'b1;
`ifdef RF_WB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                    // The cap beat closes the burst even without req_last.
                    if (beat_last || at_cap) begin
                        state_d    = IDLE;
                        rr_ptr_d   = ptr_inc(owner_q);
                        beat_cnt_d = '0;
                        len_err_d  = !beat_last;
                    end
                end
`ifdef RF_WB_TIMEOUT_EN
                else begin
                    // Only the owner can be ready here, so no accept means the owner stalled.
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = ptr_inc(owner_q);
                        beat_cnt_d = '0;
                        to_cnt_d   = '0;
                        timeout_d  = 1'b1;
                    end else begin
                        to_cnt_d   = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.len_err   = len_err_q;
`ifdef RF_WB_TIMEOUT_EN
    assign bus.timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NUM_REQ(3)) bus ();

    rf_wb_arbiter #(
        .NUM_REQ   (3),
        .MAX_BURST (8),
        .TIMEOUT   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [2:0]  valid;
        logic [2:0]  last;
        logic [14:0] base;
        logic [31:0] dseed;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic        exp_len;
        logic        exp_busy;
    } vec_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[$];
    wr_t  sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [2:0] v, input logic [2:0] l,
                                input logic [4:0] b0, input logic [4:0] b1, input logic [4:0] b2,
                                input logic [31:0] seed, input logic [2:0] r, input logic we,
                                input logic [4:0] a, input logic len, input logic bsy);
        vec_t t;
        t.valid = v; t.last = l; t.base = {b2, b1, b0}; t.dseed = seed;
        t.exp_ready = r; t.exp_we = we; t.exp_addr = a; t.exp_len = len; t.exp_busy = bsy;
        tbl.push_back(t);
    endfunction

    // Drive one cycle, check the combinational grant, then the registered outputs.
    task automatic run_vec(input vec_t v);
        int  idx;
        wr_t w;
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_last  = v.last;
        bus.req_base  = v.base;
        bus.req_data  = {v.dseed ^ 32'h2222_0000, v.dseed ^ 32'h1111_0000, v.dseed};
        #1;
        check("req_ready", 64'(bus.req_ready), 64'(v.exp_ready));
        if (v.exp_we) begin
            idx    = v.exp_ready[2] ? 2 : (v.exp_ready[1] ? 1 : 0);
            w.addr = v.exp_addr;
            w.data = v.dseed ^ (32'(idx) * 32'h1111_0000);
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        check("rf_we", 64'(bus.rf_we), 64'(v.exp_we));
        if (bus.rf_we && sb.size() > 0) begin
            w = sb.pop_front();
            check("rf_waddr", 64'(bus.rf_waddr), 64'(w.addr));
            check("rf_wdata", 64'(bus.rf_wdata), 64'(w.data));
        end else if (sb.size() > 0) begin
            void'(sb.pop_front());
        end
        check("len_err", 64'(bus.len_err), 64'(v.exp_len));
        check("busy", 64'(bus.busy), 64'(v.exp_busy));
    endtask

    initial begin
        vec_t v;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_base  = '0;
        bus.req_data  = '0;

        // Reset: grants suppressed even with every requester valid.
        add(3'b111, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        run_vec(tbl.pop_front());
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        rst_n = 1'b1;

        // ALU single write, then idle.
        add(3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 3'b001, 1'b1, 5'd5, 1'b0, 1'b0);
        add(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        // Load then crypto singles walk rr_ptr back to 0.
        add(3'b010, 3'b010, 5'd0, 5'd7, 5'd0, 32'h0000_0707, 3'b010, 1'b1, 5'd7, 1'b0, 1'b0);
        add(3'b100, 3'b100, 5'd0, 5'd0, 5'd9, 32'h0000_0909, 3'b100, 1'b1, 5'd9, 1'b0, 1'b0);
        // All valid singles: round-robin ALU, load, crypto.
        add(3'b111, 3'b111, 5'd10, 5'd11, 5'd12, 32'h0000_1010, 3'b001, 1'b1, 5'd10, 1'b0, 1'b0);
        add(3'b111, 3'b111, 5'd10, 5'd11, 5'd12, 32'h0000_1111, 3'b010, 1'b1, 5'd11, 1'b0, 1'b0);
        add(3'b111, 3'b111, 5'd10, 5'd11, 5'd12, 32'h0000_1212, 3'b100, 1'b1, 5'd12, 1'b0, 1'b0);
        // Crypto 4-beat burst at 30 with ALU waiting: 30, 31, 1, 2 then ALU without bubble.
        add(3'b100, 3'b000, 5'd3, 5'd0, 5'd30, 32'h0000_3030, 3'b100, 1'b1, 5'd30, 1'b0, 1'b1);
        add(3'b101, 3'b001, 5'd3, 5'd0, 5'd30, 32'h0000_3131, 3'b100, 1'b1, 5'd31, 1'b0, 1'b1);
        add(3'b101, 3'b001, 5'd3, 5'd0, 5'd30, 32'h0000_0101, 3'b100, 1'b1, 5'd1, 1'b0, 1'b1);
        add(3'b101, 3'b101, 5'd3, 5'd0, 5'd30, 32'h0000_0202, 3'b100, 1'b1, 5'd2, 1'b0, 1'b0);
        add(3'b101, 3'b101, 5'd3, 5'd0, 5'd30, 32'h0000_0303, 3'b001, 1'b1, 5'd3, 1'b0, 1'b0);
        add(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        // Load single to register 0: accepted, never written.
        add(3'b010, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0000_00AA, 3'b010, 1'b0, 5'd0, 1'b0, 1'b0);
        // Crypto burst without last: capped at 8 beats, len_err with the 8th write.
        for (int k = 0; k < 8; k++) begin
            add(3'b100, 3'b000, 5'd0, 5'd0, 5'd4, 32'h00C0_0000 + 32'(k), 3'b100, 1'b1,
                5'(4 + k), (k == 7), (k != 7));
        end
        add(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        // Load single moves rr_ptr to 2 ahead of the reset test.
        add(3'b010, 3'b010, 5'd0, 5'd13, 5'd0, 32'h0000_1313, 3'b010, 1'b1, 5'd13, 1'b0, 1'b0);

        for (int i = 0; i < $size(tbl); i++) begin
            run_vec(tbl[i]);
        end

        // Reset in the middle of an ALU burst.
        add(3'b001, 3'b000, 5'd20, 5'd0, 5'd0, 32'h0000_2020, 3'b001, 1'b1, 5'd20, 1'b0, 1'b1);
        run_vec(tbl[$size(tbl)-1]);
        add(3'b001, 3'b000, 5'd20, 5'd0, 5'd0, 32'h0000_2121, 3'b001, 1'b1, 5'd21, 1'b0, 1'b1);
        run_vec(tbl[$size(tbl)-1]);
        rst_n = 1'b0;
        add(3'b001, 3'b000, 5'd20, 5'd0, 5'd0, 32'h0000_2222, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0);
        run_vec(tbl[$size(tbl)-1]);
        check("rst_mid_waddr", 64'(bus.rf_waddr), 64'd0);
        rst_n = 1'b1;
        // rr_ptr back at 0: ALU wins over load and crypto.
        add(3'b111, 3'b111, 5'd14, 5'd15, 5'd16, 32'h0000_1414, 3'b001, 1'b1, 5'd14, 1'b0, 1'b0);
        run_vec(tbl[$size(tbl)-1]);

`ifdef RF_WB_TIMEOUT_EN
        // rr_ptr=1: crypto starts a burst alone, then stalls while ALU waits.
        add(3'b100, 3'b000, 5'd3, 5'd0, 5'd1, 32'h0000_5151, 3'b100, 1'b1, 5'd1, 1'b0, 1'b1);
        run_vec(tbl[$size(tbl)-1]);
        for (int k = 0; k < 16; k++) begin
            v = '0;
            v.valid = 3'b001; v.last = 3'b001; v.base = {5'd0, 5'd0, 5'd3};
            v.exp_ready = 3'b100; v.exp_busy = (k != 15);
            run_vec(v);
            check("timeout_err", 64'(bus.timeout_err), 64'(k == 15));
        end
        add(3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'h0000_0303, 3'b001, 1'b1, 5'd3, 1'b0, 1'b0);
        run_vec(tbl[$size(tbl)-1]);
        check("timeout_clear", 64'(bus.timeout_err), 64'd0);
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
